// File: rtl/program_counter.sv
// Fetch-stage program counter: sequences the instruction ROM address through
// start/halt, increment, relative branch, absolute jump and stall, and counts retired instructions.
module program_counter #(
  parameter int ADDR_W     = 7,
  parameter int NUM_INSTR  = 128,
  parameter int START_ADDR = 0,
  parameter int OFF_W      = 5,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              jump_abs,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [OFF_W-1:0]  branch_off,
  output logic [ADDR_W-1:0] address,
  output logic              running,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);
  // One extra bit so NUM_INSTR == 2^ADDR_W is representable (never trips).
  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(NUM_INSTR);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              err_reg, err_next;
  logic [CNT_W-1:0]  ret_reg, ret_next;

  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] target;
  logic [CNT_W-1:0]  ret_inc;

  assign off_ext = ADDR_W'($signed(branch_off));
  assign ret_inc = (ret_reg == '1) ? ret_reg : ret_reg + CNT_W'(1);

  always_comb begin
    target = addr_reg + ADDR_W'(1);
    if (jump_abs) begin
      target = jump_target;
    end else if (branch_taken) begin
      target = addr_reg + off_ext;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    err_next   = err_reg;
    ret_next   = ret_reg;
    case (state_reg)
      IDLE, HALTED: begin
        if (start) begin
          state_next = RUN;
          addr_next  = START;
          err_next   = 1'b0;
          ret_next   = '0;
        end
      end
      RUN: begin
        if (halt_req) begin
          state_next = HALTED;
          err_next   = 1'b0;
          ret_next   = ret_inc;
        end else if (!stall) begin
          ret_next = ret_inc;
          // An out-of-range target halts with the address frozen on the offender's source.
          if ({1'b0, target} >= LIMIT) begin
            state_next = HALTED;
            err_next   = 1'b1;
          end else begin
            addr_next = target;
          end
        end
      end
      default: begin
        state_next = IDLE;
        addr_next  = START;
        err_next   = 1'b0;
        ret_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      addr_reg  <= START;
      err_reg   <= 1'b0;
      ret_reg   <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      err_reg   <= err_next;
      ret_reg   <= ret_next;
    end
  end

  assign address = addr_reg;
  assign running = (state_reg == RUN);
  assign done    = (state_reg == HALTED);
  assign err     = err_reg;
  assign retired = ret_reg;

endmodule
